jk_cmd_driver: RTL

Upstream command stage for the JK flip-flop. It accepts hold/clear/set/toggle commands on a valid/ready handshake and buffers them in a small FIFO. It replays each command onto registered `j`/`k` outputs for a programmable number of cycles. An optional shadow checker compares the flip-flop's `q` feedback against the expected value and raises a sticky error.

---
 rtl/jk_cmd_driver.sv | 131 +++++++++++++
 1 files changed

// File: rtl/jk_cmd_driver.sv
// jk_cmd_driver: command stage in front of a JK flip-flop.
// Buffers hold/clear/set/toggle commands in a DEPTH-entry FIFO and replays each
// one onto registered j/k for max(len,1) consecutive cycles, back-to-back.
// Optional feature macro: JK_CMD_CHECK_EN adds a shadow model of the flip-flop
// and a sticky err flag on q_fb mismatch; without it err is tied 0.
// Ports:
//   clk, reset     - clock; synchronous active-high reset
//   cmd_valid/ready- command handshake (ready = !full && !reset)
//   cmd_op         - 00 hold, 01 clear, 10 set, 11 toggle
//   cmd_len        - cycles to apply cmd_op (0 behaves as 1)
//   j, k           - registered drive to the flip-flop
//   busy           - a command is issuing or commands are queued
//   q_fb           - flip-flop output, used by the checker only
//   err            - sticky mismatch flag
module jk_cmd_driver #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_len,
  output logic             j,
  output logic             k,
  output logic             busy,
  input  logic             q_fb,
  output logic             err
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef struct packed {
    logic [1:0]       op;
    logic [CNT_W-1:0] len;
  } cmd_t;

  typedef enum logic {IDLE, ISSUE} state_t;

  cmd_t             mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  state_t           state;
  logic [CNT_W-1:0] remaining;

  logic             empty;
  logic             full;
  logic             push;
  logic             pop;
  cmd_t             head;
  logic [CNT_W-1:0] head_rem;

  // Extra pointer bit separates full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign cmd_ready = !full && !reset;
  assign push      = cmd_valid && cmd_ready;
  assign busy      = (state == ISSUE) || !empty;

  // Pop when idle, or when the issuing command is on its last cycle.
  assign head     = mem[rd_ptr[AW-1:0]];
  assign pop      = !empty && ((state == IDLE) || (remaining == '0));
  assign head_rem = (head.len == '0) ? '0 : head.len - CNT_W'(1);

  // FIFO storage; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= '{op: cmd_op, len: cmd_len};
    end
  end

  // Pointers and issue FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      state     <= IDLE;
      remaining <= '0;
      j         <= 1'b0;
      k         <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (pop) begin
        rd_ptr    <= rd_ptr + (AW+1)'(1);
        state     <= ISSUE;
        remaining <= head_rem;
        j         <= head.op[1];
        k         <= head.op[0];
      end else if (state == ISSUE) begin
        if (remaining != '0) begin
          remaining <= remaining - CNT_W'(1);
        end else begin
          state <= IDLE;
          j     <= 1'b0;
          k     <= 1'b0;
        end
      end
    end
  end

`ifdef JK_CMD_CHECK_EN
  logic q_exp;

  // Shadow flip-flop fed by the same j/k; any divergence from q_fb latches err.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_exp <= 1'b0;
      err   <= 1'b0;
    end else begin
      case ({j, k})
        2'b01:   q_exp <= 1'b0;
        2'b10:   q_exp <= 1'b1;
        2'b11:   q_exp <= ~q_exp;
        default: q_exp <= q_exp;
      endcase
      if (q_fb != q_exp) begin
        err <= 1'b1;
      end
    end
  end
`else
  logic unused_q_fb;
  assign unused_q_fb = q_fb;
  assign err         = 1'b0;
`endif

endmodule
